// File: rtl/ir_strobe_ctrl.sv
// ----------------------------------------------------------------------------
// ir_strobe_ctrl : frame-synchronous IR500 strobe sequencer
//   Bias warm-up, per-channel PWM on-time, then an equal-length cooldown.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ir_strobe_ctrl #(
  parameter int PWM_BITS      = 8,
  parameter int CNT_W         = 16,
  parameter int WARMUP_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_enable,
  input  logic [1:0]          cfg_ch_en,
  input  logic [CNT_W-1:0]    cfg_on_cycles,
  input  logic [PWM_BITS-1:0] cfg_duty1,
  input  logic [PWM_BITS-1:0] cfg_duty2,
  input  logic                trigger,
  output logic                curren,
  output logic                irleden,
  output logic                irpwm,
  output logic                irleden2,
  output logic                irpwm2,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WARMUP   = 2'd1,
    S_ON       = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WU_W-1:0]     wu_cnt_q, wu_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [CNT_W-1:0]    on_q, on_d;
  logic [1:0]          ch_q, ch_d;
  logic [PWM_BITS-1:0] duty1_q, duty1_d;
  logic [PWM_BITS-1:0] duty2_q, duty2_d;
  logic                overrun_q, overrun_d;

  logic curren_q, curren_d;
  logic irleden_q, irleden_d;
  logic irpwm_q, irpwm_d;
  logic irleden2_q, irleden2_d;
  logic irpwm2_q, irpwm2_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic w_accept;
  logic w_on_last;
  logic w_led_phase;

  assign w_accept  = trigger && cfg_enable && (cfg_on_cycles != '0) && (cfg_ch_en != 2'b00);
  assign w_on_last = (cnt_q == on_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wu_cnt_q   <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
      on_q       <= '0;
      ch_q       <= 2'b00;
      duty1_q    <= '0;
      duty2_q    <= '0;
      overrun_q  <= 1'b0;
      curren_q   <= 1'b0;
      irleden_q  <= 1'b0;
      irpwm_q    <= 1'b0;
      irleden2_q <= 1'b0;
      irpwm2_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wu_cnt_q   <= wu_cnt_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      on_q       <= on_d;
      ch_q       <= ch_d;
      duty1_q    <= duty1_d;
      duty2_q    <= duty2_d;
      overrun_q  <= overrun_d;
      curren_q   <= curren_d;
      irleden_q  <= irleden_d;
      irpwm_q    <= irpwm_d;
      irleden2_q <= irleden2_d;
      irpwm2_q   <= irpwm2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next state plus the shadow config; the ON/COOLDOWN counter is shared.
  always_comb begin
    state_d   = state_q;
    wu_cnt_d  = wu_cnt_q;
    cnt_d     = cnt_q;
    pwm_d     = pwm_q;
    on_d      = on_q;
    ch_d      = ch_q;
    duty1_d   = duty1_q;
    duty2_d   = duty2_q;
    overrun_d = overrun_q | (trigger && (state_q != S_IDLE));
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          on_d     = cfg_on_cycles;
          ch_d     = cfg_ch_en;
          duty1_d  = cfg_duty1;
          duty2_d  = cfg_duty2;
          wu_cnt_d = '0;
          state_d  = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (!cfg_enable) begin
          cnt_d   = '0;
          state_d = S_COOLDOWN;
        end else if (wu_cnt_q == WU_LAST) begin
          cnt_d   = '0;
          pwm_d   = '0;
          state_d = S_ON;
        end else begin
          wu_cnt_d = wu_cnt_q + WU_W'(1);
        end
      end
      S_ON: begin
        if (!cfg_enable) begin
          cnt_d   = '0;
          state_d = S_COOLDOWN;
        end else if (w_on_last) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_COOLDOWN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          pwm_d = pwm_q + PWM_BITS'(1);
        end
      end
      S_COOLDOWN: begin
        if (w_on_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    w_led_phase = (state_d == S_ON);
    curren_d    = (state_d == S_WARMUP) || (state_d == S_ON);
    irleden_d   = w_led_phase && ch_q[0];
    irleden2_d  = w_led_phase && ch_q[1];
    irpwm_d     = w_led_phase && ch_q[0] && (pwm_d < duty1_q);
    irpwm2_d    = w_led_phase && ch_q[1] && (pwm_d < duty2_q);
    busy_d      = (state_d != S_IDLE);
  end

  assign curren   = curren_q;
  assign irleden  = irleden_q;
  assign irpwm    = irpwm_q;
  assign irleden2 = irleden2_q;
  assign irpwm2   = irpwm2_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;

  a_bias_before_led: assert property (@(posedge clk) disable iff (rst)
    (irleden || irleden2) |-> curren);
  a_pwm1_gated: assert property (@(posedge clk) disable iff (rst) irpwm |-> irleden);
  a_pwm2_gated: assert property (@(posedge clk) disable iff (rst) irpwm2 |-> irleden2);

endmodule

`default_nettype wire

// File: tb/tb_ir_strobe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ir_strobe_ctrl : vector table, directed corner sequences, random vs model
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ir_strobe_ctrl;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [1:0]  cfg_ch_en;
  logic [15:0] cfg_on_cycles;
  logic [7:0]  cfg_duty1;
  logic [7:0]  cfg_duty2;
  logic        trigger;
  logic        curren, irleden, irpwm, irleden2, irpwm2, busy, done, overrun;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc;

  ir_strobe_ctrl #(.PWM_BITS(8), .CNT_W(16), .WARMUP_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_ch_en(cfg_ch_en),
    .cfg_on_cycles(cfg_on_cycles), .cfg_duty1(cfg_duty1), .cfg_duty2(cfg_duty2),
    .trigger(trigger), .curren(curren), .irleden(irleden), .irpwm(irpwm),
    .irleden2(irleden2), .irpwm2(irpwm2), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  ch;
    int          on;
    int          d1;
    int          d2;
    int          e_cur;
    int          e_led1;
    int          e_led2;
    int          e_pwm1;
    int          e_pwm2;
    int          e_done_at;
    int          e_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {curren, irleden, irpwm, irleden2, irpwm2, busy, done, overrun};
  endfunction

  // Sample point and input-drive point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; trigger = 1'b0; cfg_enable = 1'b1; cfg_ch_en = 2'b00;
    cfg_on_cycles = '0; cfg_duty1 = '0; cfg_duty2 = '0;
    tick();
    check("reset outputs", {24'd0, dut_vec()}, 32'd0);
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic start_strobe(input logic en, input logic [1:0] ch, input int on,
                              input int d1, input int d2);
    cfg_enable = en; cfg_ch_en = ch; cfg_on_cycles = 16'(on);
    cfg_duty1 = 8'(d1); cfg_duty2 = 8'(d2);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic run_until(input longint target);
    while (cyc < target) tick();
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int ncur, nl1, nl2, np1, np2, nb, ndone, done_at, k;
    logic ovr;
    ncur = 0; nl1 = 0; nl2 = 0; np1 = 0; np2 = 0; nb = 0; ndone = 0; done_at = -1; ovr = 0;
    do_reset();
    start_strobe(v.en, v.ch, v.on, v.d1, v.d2);
    k = 1;
    while (k < 3000) begin
      ncur += int'(curren); nl1 += int'(irleden); nl2 += int'(irleden2);
      np1 += int'(irpwm); np2 += int'(irpwm2); nb += int'(busy);
      if (done) begin ndone++; done_at = k; end
      ovr |= overrun;
      if (!busy && k >= 2) break;
      tick();
      k++;
    end
    check($sformatf("v%0d timeout", id), 32'(k >= 3000), 32'd0);
    check($sformatf("v%0d curren cycles", id), ncur, v.e_cur);
    check($sformatf("v%0d irleden cycles", id), nl1, v.e_led1);
    check($sformatf("v%0d irleden2 cycles", id), nl2, v.e_led2);
    check($sformatf("v%0d irpwm cycles", id), np1, v.e_pwm1);
    check($sformatf("v%0d irpwm2 cycles", id), np2, v.e_pwm2);
    check($sformatf("v%0d done cycle", id), done_at, v.e_done_at);
    check($sformatf("v%0d done pulses", id), ndone, (v.e_done_at < 0) ? 0 : 1);
    check($sformatf("v%0d busy cycles", id), nb, v.e_busy);
    check($sformatf("v%0d overrun", id), 32'(ovr), 32'd0);
  endtask

  // Reference model: a strobe is a set of absolute-cycle windows.
  logic        m_act, m_ovr, m_abort;
  longint      m_t0, m_cs, m_bend;
  int          m_on, m_d1, m_d2;
  logic [1:0]  m_ch;

  function automatic logic [7:0] m_expect(input longint c);
    logic cur, l1, p1, l2, p2, b, d, win;
    longint onst, ph;
    cur = 0; l1 = 0; p1 = 0; l2 = 0; p2 = 0; b = 0; d = 0;
    if (m_act) begin
      onst = m_t0 + W + 1;
      b    = (c >= m_t0 + 1) && (c <= m_bend);
      cur  = (c >= m_t0 + 1) && (c < m_cs);
      win  = (c >= onst) && (c < m_cs);
      ph   = (c - onst) % 256;
      l1   = win && m_ch[0];
      l2   = win && m_ch[1];
      p1   = l1 && (ph < m_d1);
      p2   = l2 && (ph < m_d2);
      d    = !m_abort && (c == m_cs);
    end
    return {cur, l1, p1, l2, p2, b, d, m_ovr};
  endfunction

  task automatic m_update(input longint c);
    logic mbusy;
    if (rst) begin
      m_act = 0; m_ovr = 0;
      return;
    end
    mbusy = m_act && (c >= m_t0 + 1) && (c <= m_bend);
    if (mbusy) begin
      if (trigger) m_ovr = 1;
      if (!cfg_enable && c < m_cs) begin
        m_abort = 1; m_cs = c + 1; m_bend = c + m_on;
      end
    end else if (trigger && cfg_enable && cfg_on_cycles != 0 && cfg_ch_en != 0) begin
      m_act = 1; m_abort = 0; m_t0 = c;
      m_on = int'(cfg_on_cycles); m_ch = cfg_ch_en;
      m_d1 = int'(cfg_duty1); m_d2 = int'(cfg_duty2);
      m_cs = c + W + m_on + 1; m_bend = m_cs + m_on - 1;
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   r;
    //          en    ch     on   d1   d2   cur  led1 led2 pwm1 pwm2 done busy
    vecs[0] = '{1'b1, 2'b01, 100, 128, 0,   164, 100, 0,   100, 0,   165, 264};
    vecs[1] = '{1'b1, 2'b11, 600, 0,   255, 664, 600, 600, 0,   598, 665, 1264};
    vecs[2] = '{1'b1, 2'b11, 0,   50,  50,  0,   0,   0,   0,   0,   -1,  0};
    vecs[3] = '{1'b1, 2'b00, 50,  50,  50,  0,   0,   0,   0,   0,   -1,  0};
    vecs[4] = '{1'b0, 2'b01, 50,  50,  50,  0,   0,   0,   0,   0,   -1,  0};
    vecs[5] = '{1'b1, 2'b10, 3,   9,   2,   67,  0,   3,   0,   2,   68,  70};
    vecs[6] = '{1'b1, 2'b01, 1,   1,   0,   65,  1,   0,   1,   0,   66,  66};

    cyc = 0;
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Overrun on a second trigger, then a third trigger in the first idle cycle.
    do_reset();
    start_strobe(1'b1, 2'b01, 10, 5, 0);
    run_until(20);
    trigger = 1'b1;
    check("ovr before 2nd", 32'(overrun), 32'd0);
    tick();
    trigger = 1'b0;
    check("ovr after 2nd", 32'(overrun), 32'd1);
    while (busy && cyc < 500) tick();
    check("first idle cycle", 32'(cyc), 32'd85);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("3rd accepted busy", 32'(busy), 32'd1);
    check("3rd accepted curren", 32'(curren), 32'd1);
    check("ovr sticky", 32'(overrun), 32'd1);
    run_until(149);
    check("3rd led before on", {30'd0, curren, irleden}, 32'd2);
    tick();
    check("3rd led on", {30'd0, curren, irleden}, 32'd3);

    // Trigger in the last COOLDOWN cycle is ignored but flags overrun.
    do_reset();
    start_strobe(1'b1, 2'b10, 2, 0, 255);
    run_until(68);
    check("last cooldown busy", 32'(busy), 32'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("late trig busy", 32'(busy), 32'd0);
    check("late trig overrun", 32'(overrun), 32'd1);
    tick();
    check("late trig not started", 32'(busy), 32'd0);

    // Abort 30 cycles into ON.
    do_reset();
    start_strobe(1'b1, 2'b01, 100, 200, 0);
    run_until(95);
    check("abort pre led", 32'(irleden), 32'd1);
    cfg_enable = 1'b0;
    tick();
    check("abort outputs", {24'd0, dut_vec()}, 32'h04);
    begin
      int nb, nd;
      nb = 0; nd = 0;
      while (busy && nb < 500) begin
        nb++;
        nd += int'(done);
        if (cyc == 120) cfg_enable = 1'b1;
        tick();
      end
      check("abort busy cycles", nb, 100);
      check("abort no done", nd, 0);
    end

    // Reset during ON with overrun set.
    do_reset();
    start_strobe(1'b1, 2'b11, 100, 100, 100);
    run_until(10);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    run_until(80);
    check("pre-rst overrun", {30'd0, overrun, irleden}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post-rst outputs", {24'd0, dut_vec()}, 32'd0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("post-rst accept", {29'd0, busy, curren, overrun}, 32'd6);

    // Random traffic against the window model.
    do_reset();
    m_act = 0; m_ovr = 0; m_abort = 0;
    for (int i = 0; i < 20000; i++) begin
      check("random outputs", {24'd0, dut_vec()}, {24'd0, m_expect(cyc)});
      rst     = ($urandom_range(0, 999) < 2);
      trigger = ($urandom_range(0, 99) < 4);
      cfg_enable = ($urandom_range(0, 999) >= 15);
      if ($urandom_range(0, 9) < 3) begin
        r = $urandom_range(0, 99);
        cfg_on_cycles = (r < 8) ? 16'd0 :
                        (r < 11) ? 16'($urandom_range(200, 600)) : 16'($urandom_range(1, 40));
        cfg_ch_en = 2'($urandom_range(0, 3));
        cfg_duty1 = 8'($urandom_range(0, 255));
        cfg_duty2 = 8'($urandom_range(0, 255));
      end
      m_update(cyc);
      tick();
    end
    rst = 1'b0; trigger = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ir_strobe_ctrl.md
Name: ir_strobe_ctrl

Overview:
- Sequences the iCE40UP IR500 LED driver for frame-synchronous IR illumination.
- On a camera frame trigger it:
  1. enables the driver bias (CURREN),
  2. waits a settle time,
  3. drives one or both IR LED channels with per-channel 8-bit PWM for a programmed on-time,
  4. enforces a cooldown equal to the on-time, capping LED duty at 50%.
- Sits between the camera timing/register block and the IR500 driver primitive.

Parameters:
- PWM_BITS, 8, width of the PWM counter and duty inputs.
- CNT_W, 16, width of the on-time counter and cooldown counter.
- WARMUP_CYCLES, 64, number of cycles CURREN is high before any LED enable.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  master enable; low aborts any strobe in progress.
- cfg_ch_en  in  2  channel enables; bit0 = LED1, bit1 = LED2.
- cfg_on_cycles  in  CNT_W  LED on-time in clk cycles; 0 means strobe ignored.
- cfg_duty1  in  PWM_BITS  LED1 duty; high while pwm_cnt < duty.
- cfg_duty2  in  PWM_BITS  LED2 duty.
- trigger  in  1  single-cycle frame strobe request.
- curren  out  1  to driver CURREN.
- irleden  out  1  to driver IRLEDEN.
- irpwm  out  1  to driver IRPWM.
- irleden2  out  1  to driver IRLEDEN2.
- irpwm2  out  1  to driver IRPWM2.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the ON phase completes normally.
- overrun  out  1  sticky; set when a trigger arrives while busy. Cleared only by rst.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0. After reset: state IDLE, all counters 0, latched config 0.
- FSM states: IDLE, WARMUP, ON, COOLDOWN.
- IDLE:
  - All driver outputs are low.
  - Exit condition: trigger && cfg_enable && cfg_on_cycles != 0 && cfg_ch_en != 0.
  - Action on exit: latch cfg_on_cycles, cfg_ch_en, cfg_duty1 and cfg_duty2 into shadow registers, then go to WARMUP.
  - A trigger with any other config does nothing and leaves overrun unchanged.
- Trigger latency:
  - Trigger sampled in cycle T → curren = 1 in cycle T+1.
  - curren stays high for exactly WARMUP_CYCLES cycles (T+1 … T+WARMUP_CYCLES) before the ON phase begins.
- WARMUP → ON:
  - In cycle T+WARMUP_CYCLES+1, irleden = ch_en[0] and irleden2 = ch_en[1]; curren stays 1.
  - pwm_cnt is 0 in the first ON cycle and increments by 1 each cycle, wrapping modulo 2^PWM_BITS.
- ON phase:
  - irpwm = ch_en[0] && (pwm_cnt < duty1); irpwm2 = ch_en[1] && (pwm_cnt < duty2).
  - duty 0 gives constant low. duty 255 gives 255 high cycles per 256.
  - ON lasts exactly on_cycles (latched value) cycles.
  - done pulses in the last ON cycle + 1, i.e. the first COOLDOWN cycle.
- COOLDOWN:
  - curren, irleden, irleden2, irpwm and irpwm2 are all 0.
  - Lasts exactly on_cycles (latched value) cycles, then returns to IDLE.
  - busy drops in the first IDLE cycle.
- Mid-strobe config changes: cfg_* changes while busy have no effect until the next accepted trigger, because the shadow registers are used.
- Trigger while busy: ignored; overrun is set to 1 in the next cycle.
- Abort: cfg_enable low in WARMUP or ON →
  - next cycle all driver outputs are 0 and the state goes to COOLDOWN;
  - cooldown length is the full latched on_cycles;
  - done is not pulsed.
  - cfg_enable low in COOLDOWN has no additional effect.
- Trigger in the same cycle COOLDOWN ends: ignored (state is still busy) and sets overrun.
- rst asserted mid-operation: the next cycle is a full reset state, all outputs 0, overrun cleared.
- Invariants, checked by assertions:
  - curren never 0 while irleden or irleden2 is 1.
  - irpwm → irleden; irpwm2 → irleden2.

Test Plan:
- WARMUP_CYCLES = 64, on_cycles = 100, ch_en = 2'b01, duty1 = 128, trigger at cycle 10 →
  - curren high cycles 11–174;
  - irleden high cycles 75–174;
  - irpwm high 128 of 256 PWM phases (cycles 75–174, so high 75–174 since pwm_cnt < 128 throughout 100 cycles);
  - done at 175;
  - busy low from 275.
- ch_en = 2'b11, duty1 = 0, duty2 = 255, on_cycles = 600 → irpwm never high; irpwm2 low exactly on cycles where pwm_cnt == 255 (twice in 600 cycles).
- Second trigger 20 cycles after the first, then a third in the first IDLE cycle → overrun = 1 after the second trigger; the third starts a new strobe normally.
- cfg_enable deasserted 30 cycles into ON with on_cycles = 100 → LED outputs 0 next cycle, no done, busy held for 100 further cycles.
- cfg_on_cycles = 0 or cfg_ch_en = 0 with trigger → busy stays 0, all outputs stay 0, overrun stays 0.
- rst pulsed during ON with overrun set → all outputs 0 and overrun 0 on the following cycle; the next trigger is accepted.
